ram_table_writer: RTL and testbench
===================================

RAM_TABLE_WRITER -- requirements
Module: ram_table_writer

Interface
REQ-001 Parameter ADDR_W, default 3: address width; depth is 2**ADDR_W entries.
REQ-002 Parameter DATA_W, default 8: data word width.
REQ-003 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port wr_valid, input, 1 bit: write request present.
REQ-006 Port wr_ready, output, 1 bit: block can accept a write this cycle.
REQ-007 Port wr_addr, input, ADDR_W bits: write address.
REQ-008 Port wr_data, input, DATA_W bits: write data.
REQ-009 Port rd_en, input, 1 bit: read request.
REQ-010 Port rd_addr, input, ADDR_W bits: read address.
REQ-011 Port rd_data, output, DATA_W bits: registered read data.
REQ-012 Port rd_valid, output, 1 bit: rd_data updated by a read on the previous edge.
REQ-013 Port reinit, input, 1 bit: request to reload the default table.
REQ-014 Port init_done, output, 1 bit: default table fully loaded.
REQ-015 Port wr_cnt, output, 8 bits: count of accepted writes.

Function
REQ-016 The block SHALL hold a 2**ADDR_W x DATA_W register-array memory and an FSM with two states, INIT and IDLE.
REQ-017 The default table SHALL be, for addr 0..7: 10, 13, 40, 50, 20, 100, 130, 0; for ADDR_W>3, entries above 7 default to 0.
REQ-018 In INIT, an internal load pointer SHALL write one default entry per edge, starting at 0 and incrementing by 1.
REQ-019 The edge that writes the last entry SHALL set init_done=1 and move to IDLE; depth 8 means exactly 8 edges after reset release.
REQ-020 wr_ready SHALL equal 1 only in IDLE; it is a registered state decode, not a function of inputs.
REQ-021 A write SHALL be accepted on an edge with wr_valid=1 and wr_ready=1: mem[wr_addr] <= wr_data; wr_cnt increments by 1.
REQ-022 wr_cnt SHALL wrap from 255 to 0; INIT loads SHALL NOT count.
REQ-023 wr_valid while wr_ready=0 SHALL be ignored; nothing is written or counted.
REQ-024 A read SHALL occur on an edge in IDLE with rd_en=1: rd_data <= mem[rd_addr]; rd_valid=1 for the next cycle.
REQ-025 Read latency SHALL be 1 clock.
REQ-026 rd_valid SHALL be 0 after any edge without a read; rd_data SHALL hold its last value (never X).
REQ-027 rd_en in INIT SHALL be ignored: rd_valid=0, rd_data unchanged.
REQ-028 A read and write to the same address on the same edge SHALL return the old data (read-before-write).
REQ-029 reinit=1 in IDLE SHALL move to INIT on that edge, clear init_done and reset the load pointer to 0.
REQ-030 A write accepted on that same reinit edge SHALL still be performed and counted; INIT later overwrites it.
REQ-031 reinit asserted during INIT SHALL be ignored.

Reset
REQ-032 rst_n=0 SHALL immediately force state=INIT, load pointer=0, init_done=0, wr_ready=0, rd_valid=0, rd_data=0, wr_cnt=0.
REQ-033 Memory contents SHALL NOT be reset directly; they are defined only by the INIT sequence.
REQ-034 Reset asserted mid-INIT or mid-operation SHALL restart INIT from entry 0 after release.

Verification
REQ-035 Release reset, idle 8 edges -> init_done=1 and wr_ready=1 after edge 8; read addr 0..6 -> rd_data 10, 13, 40, 50, 20, 100, 130, each with rd_valid one cycle later.
REQ-036 In IDLE, write addr 5 with 8'd77 -> wr_cnt=1; read addr 5 -> 77.
REQ-037 Same-edge read and write to addr 2 with 8'd99 -> rd_data=40; a following read -> 99.
REQ-038 Hold wr_valid=1 with addr 3, data 8'd1 during INIT -> wr_cnt=0; after INIT, mem[3]=50.
REQ-039 Pulse reinit after writing addr 0 with 8'd5 -> wr_ready=0 for 8 cycles; then read addr 0 -> 10.
REQ-040 Accept 256 writes -> wr_cnt=0; assert rst_n=0 at load pointer 4 -> init_done=0 immediately, and the full 8-edge INIT repeats after release.

Source files
------------

// File: rtl/ram_table_writer_if.sv
// Bus bundle for ram_table_writer: write handshake, read port, reinit control and status.
// The master side drives requests; the slave side (the table writer) returns status and read data.
interface ram_table_writer_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              reinit;
    logic              init_done;
    logic [7:0]        wr_cnt;

    modport master (
        output wr_valid, wr_addr, wr_data, rd_en, rd_addr, reinit,
        input  wr_ready, rd_data, rd_valid, init_done, wr_cnt
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_en, rd_addr, reinit,
        output wr_ready, rd_data, rd_valid, init_done, wr_cnt
    );
endinterface

// File: rtl/ram_table_writer.sv
// Register-array lookup table that loads a fixed default table after reset or on reinit,
// then serves writes (counted) and 1-cycle read-before-write reads.
module ram_table_writer #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input logic               clk,
    input logic               rst_n,
    ram_table_writer_if.slave bus
);
    localparam int        DEPTH   = 2 ** ADDR_W;
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_IDLE = 1'b1;

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_load_ptr;
    logic              r_init_done;
    logic              r_wr_ready;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;
    logic [7:0]        r_wr_cnt;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic w_wr_accept;
    logic w_rd_fire;
    logic w_last_load;

    function automatic logic [DATA_W-1:0] default_entry(input logic [ADDR_W-1:0] a);
        logic [31:0]       idx;
        logic [DATA_W-1:0] v;
        idx = 32'(a);
        case (idx)
            32'd0:   v = DATA_W'(8'd10);
            32'd1:   v = DATA_W'(8'd13);
            32'd2:   v = DATA_W'(8'd40);
            32'd3:   v = DATA_W'(8'd50);
            32'd4:   v = DATA_W'(8'd20);
            32'd5:   v = DATA_W'(8'd100);
            32'd6:   v = DATA_W'(8'd130);
            default: v = '0;
        endcase
        return v;
    endfunction

    assign w_wr_accept = bus.wr_valid & r_wr_ready;
    assign w_rd_fire   = bus.rd_en & (r_state == ST_IDLE);
    assign w_last_load = (r_load_ptr == {ADDR_W{1'b1}});

    // Control FSM: walk the load pointer through INIT, park in IDLE until reinit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_INIT;
            r_load_ptr  <= '0;
            r_init_done <= 1'b0;
            r_wr_ready  <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_load_ptr <= r_load_ptr + ADDR_W'(1);
                    if (w_last_load) begin
                        r_state     <= ST_IDLE;
                        r_init_done <= 1'b1;
                        r_wr_ready  <= 1'b1;
                    end else begin
                        r_state     <= ST_INIT;
                    end
                end
                ST_IDLE: begin
                    if (bus.reinit) begin
                        r_state     <= ST_INIT;
                        r_load_ptr  <= '0;
                        r_init_done <= 1'b0;
                        r_wr_ready  <= 1'b0;
                    end else begin
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_INIT;
                    r_load_ptr  <= '0;
                    r_init_done <= 1'b0;
                    r_wr_ready  <= 1'b0;
                end
            endcase
        end
    end

    // Accepted-write counter; wraps naturally at 8 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_cnt <= 8'd0;
        end else if (w_wr_accept) begin
            r_wr_cnt <= r_wr_cnt + 8'd1;
        end else begin
            r_wr_cnt <= r_wr_cnt;
        end
    end

    // Registered read port; sees pre-write contents on a same-edge collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= w_rd_fire;
            if (w_rd_fire) begin
                r_rd_data <= r_mem[bus.rd_addr];
            end else begin
                r_rd_data <= r_rd_data;
            end
        end
    end

    // Table storage: INIT loads defaults, IDLE takes accepted writes; no reset on contents.
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_mem[r_load_ptr] <= default_entry(r_load_ptr);
        end else if (w_wr_accept) begin
            r_mem[bus.wr_addr] <= bus.wr_data;
        end else begin
            r_mem[bus.wr_addr] <= r_mem[bus.wr_addr];
        end
    end

    assign bus.wr_ready  = r_wr_ready;
    assign bus.init_done = r_init_done;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.rd_data   = r_rd_data;
    assign bus.wr_cnt    = r_wr_cnt;

endmodule

// File: tb/tb_ram_table_writer.sv
// Directed bench for ram_table_writer: table model compared every cycle plus literal spot checks.
module tb_ram_table_writer;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ram_table_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ram_table_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    int dflt [DEPTH] = '{10, 13, 40, 50, 20, 100, 130, 0};

    // Table-level model: remaining load edges, contents, counter, read result.
    int         init_left;
    int         exp_mem [DEPTH];
    logic [7:0] exp_cnt;
    logic [7:0] exp_rd_data;
    logic       exp_rd_valid;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_left    <= DEPTH;
            exp_cnt      <= 8'd0;
            exp_rd_data  <= 8'd0;
            exp_rd_valid <= 1'b0;
        end else if (init_left > 0) begin
            exp_mem[DEPTH-init_left] <= dflt[DEPTH-init_left];
            init_left    <= init_left - 1;
            exp_rd_valid <= 1'b0;
        end else begin
            if (bus.wr_valid) begin
                exp_mem[bus.wr_addr] <= int'(bus.wr_data);
                exp_cnt <= exp_cnt + 8'd1;
            end
            exp_rd_valid <= bus.rd_en;
            if (bus.rd_en) exp_rd_data <= 8'(exp_mem[bus.rd_addr]);
            if (bus.reinit) init_left <= DEPTH;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("cyc_init_done", 32'(bus.init_done), 32'(init_left == 0));
            chk("cyc_wr_ready",  32'(bus.wr_ready),  32'(init_left == 0));
            chk("cyc_rd_valid",  32'(bus.rd_valid),  32'(exp_rd_valid));
            chk("cyc_rd_data",   32'(bus.rd_data),   32'(exp_rd_data));
            chk("cyc_wr_cnt",    32'(bus.wr_cnt),    32'(exp_cnt));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input int a, input int exp);
        bus.rd_en   = 1'b1;
        bus.rd_addr = 3'(a);
        step();
        bus.rd_en = 1'b0;
        chk($sformatf("rd_valid_a%0d", a), 32'(bus.rd_valid), 32'd1);
        chk($sformatf("rd_data_a%0d", a), 32'(bus.rd_data), 32'(exp));
    endtask

    task automatic do_write(input int a, input int d);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 3'(a);
        bus.wr_data  = 8'(d);
        step();
        bus.wr_valid = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = 3'd0;
        bus.wr_data  = 8'd0;
        bus.rd_en    = 1'b0;
        bus.rd_addr  = 3'd0;
        bus.reinit   = 1'b0;
        repeat (3) step();
        check_en = 1'b1;
        chk("rst_init_done", 32'(bus.init_done), 32'd0);
        chk("rst_wr_ready",  32'(bus.wr_ready),  32'd0);
        chk("rst_rd_valid",  32'(bus.rd_valid),  32'd0);
        chk("rst_rd_data",   32'(bus.rd_data),   32'd0);
        chk("rst_wr_cnt",    32'(bus.wr_cnt),    32'd0);

        // Requests held through INIT must all be ignored.
        bus.wr_valid = 1'b1; bus.wr_addr = 3'd3; bus.wr_data = 8'd1;
        bus.rd_en = 1'b1; bus.rd_addr = 3'd0; bus.reinit = 1'b1;
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk($sformatf("init1_done_e%0d", i), 32'(bus.init_done), 32'(i == 8));
            chk($sformatf("init1_ready_e%0d", i), 32'(bus.wr_ready), 32'(i == 8));
            chk($sformatf("init1_rdv_e%0d", i), 32'(bus.rd_valid), 32'd0);
        end
        bus.wr_valid = 1'b0; bus.rd_en = 1'b0; bus.reinit = 1'b0;
        chk("init_wr_cnt", 32'(bus.wr_cnt), 32'd0);

        do_read(0, 10); do_read(1, 13); do_read(2, 40); do_read(3, 50);
        do_read(4, 20); do_read(5, 100); do_read(6, 130);

        do_write(5, 77);
        chk("wr5_cnt", 32'(bus.wr_cnt), 32'd1);
        do_read(5, 77);

        bus.wr_valid = 1'b1; bus.wr_addr = 3'd2; bus.wr_data = 8'd99;
        bus.rd_en = 1'b1; bus.rd_addr = 3'd2;
        step();
        bus.wr_valid = 1'b0; bus.rd_en = 1'b0;
        chk("rbw_old_data", 32'(bus.rd_data), 32'd40);
        chk("rbw_cnt", 32'(bus.wr_cnt), 32'd2);
        do_read(2, 99);
        step();
        chk("idle_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("idle_rd_hold", 32'(bus.rd_data), 32'd99);

        // Reinit with a write on the same edge; that write still counts.
        do_write(0, 5);
        bus.reinit = 1'b1; bus.wr_valid = 1'b1; bus.wr_addr = 3'd1; bus.wr_data = 8'd7;
        step();
        bus.reinit = 1'b0; bus.wr_valid = 1'b0;
        chk("reinit_cnt", 32'(bus.wr_cnt), 32'd4);
        chk("reinit_ready_c0", 32'(bus.wr_ready), 32'd0);
        for (int i = 1; i <= 7; i++) begin
            bus.reinit = (i == 3);
            step();
            bus.reinit = 1'b0;
            chk($sformatf("reinit_ready_c%0d", i), 32'(bus.wr_ready), 32'd0);
        end
        step();
        chk("reinit_ready_back", 32'(bus.wr_ready), 32'd1);
        chk("reinit_done_back", 32'(bus.init_done), 32'd1);
        do_read(0, 10);
        do_read(1, 13);

        // 4 writes so far; 252 more makes 256 accepted in total.
        bus.wr_valid = 1'b1;
        for (int i = 0; i < 252; i++) begin
            bus.wr_addr = 3'(i % 8);
            bus.wr_data = 8'(i);
            step();
            if (i == 250) chk("cnt_255", 32'(bus.wr_cnt), 32'd255);
        end
        bus.wr_valid = 1'b0;
        chk("cnt_wrap", 32'(bus.wr_cnt), 32'd0);
        do_read(3, 251);

        // Reset in the middle of INIT with the load pointer at 4.
        bus.reinit = 1'b1;
        step();
        bus.reinit = 1'b0;
        repeat (4) step();
        chk("mid_init_done", 32'(bus.init_done), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_init_done", 32'(bus.init_done), 32'd0);
        chk("async_wr_ready",  32'(bus.wr_ready),  32'd0);
        chk("async_rd_valid",  32'(bus.rd_valid),  32'd0);
        chk("async_rd_data",   32'(bus.rd_data),   32'd0);
        chk("async_wr_cnt",    32'(bus.wr_cnt),    32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk($sformatf("init2_done_e%0d", i), 32'(bus.init_done), 32'(i == 8));
        end
        for (int a = 0; a < DEPTH; a++) do_read(a, dflt[a]);
        do_read(3, 50);
        do_read(7, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
